// File: rtl/axi_lite_mem_slave_pkg.sv
// Shared definitions for the AXI4-Lite memory slave: response codes, the read and
// write FSM state types, and the byte-address to word-offset helper.
package axi_lite_mem_slave_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    R_IDLE,
    R_READ,
    R_RESP
  } rstate_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_WRITE,
    W_RESP
  } wstate_t;

  // Word offset of a byte address relative to the window base; addr[1:0] is dropped.
  function automatic logic [29:0] word_offset(input logic [31:0] addr,
                                              input logic [31:0] base);
    return 30'((addr - base) >> 2);
  endfunction

endpackage

// File: rtl/axi_lite_mem_slave_if.sv
// AXI4-Lite bus bundle (AR, R, AW, W, B channels).
// Modports: master drives addresses, write data and the ready signals of R/B;
//           slave drives the address/data readies, read data and write response.
interface axi_lite_mem_slave_if;

  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [2:0]  arprot;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [2:0]  awprot;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output araddr, arvalid, arprot, rready,
    output awaddr, awvalid, awprot, wdata, wstrb, wvalid, bready,
    input  arready, rdata, rresp, rvalid,
    input  awready, wready, bresp, bvalid
  );

  modport slave (
    input  araddr, arvalid, arprot, rready,
    input  awaddr, awvalid, awprot, wdata, wstrb, wvalid, bready,
    output arready, rdata, rresp, rvalid,
    output awready, wready, bresp, bvalid
  );

endinterface

// File: rtl/axi_lite_mem_slave_sdp_bram_we4.sv
// Simple dual-port RAM of 32-bit words: one synchronous read port and one write port
// with a 4-bit byte write enable. Read-first: a read and write to the same word on the
// same edge returns the old contents. The read register holds its value while
// rd_en_i is low. Contents are never reset.
// Ports: clk; rd_en_i, rd_addr_i, rd_data_o; wr_be_i, wr_addr_i, wr_data_i.
module axi_lite_mem_slave_sdp_bram_we4 #(
  parameter int unsigned DEPTH_WORDS = 1024
) (
  input  logic                           clk,
  input  logic                           rd_en_i,
  input  logic [$clog2(DEPTH_WORDS)-1:0] rd_addr_i,
  output logic [31:0]                    rd_data_o,
  input  logic [3:0]                     wr_be_i,
  input  logic [$clog2(DEPTH_WORDS)-1:0] wr_addr_i,
  input  logic [31:0]                    wr_data_i
);

  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] rd_data_q;

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (wr_be_i[i]) begin
        mem[wr_addr_i][8*i +: 8] <= wr_data_i[8*i +: 8];
      end
    end
    if (rd_en_i) begin
      rd_data_q <= mem[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/axi_lite_mem_slave.sv
// AXI4-Lite slave backed by a DEPTH_WORDS x 32-bit byte-writable RAM mapped at
// BASE_ADDR. Independent read and write FSMs share nothing but the RAM, so reads
// and writes proceed concurrently. Out-of-range accesses answer SLVERR and never
// touch memory.
// Ports: clk, rstn (synchronous, active-low); axi (slave modport of the AXI-Lite bundle).
module axi_lite_mem_slave
  import axi_lite_mem_slave_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input logic                 clk,
  input logic                 rstn,
  axi_lite_mem_slave_if.slave axi
);

  localparam int unsigned IdxW = $clog2(DEPTH_WORDS);

  // Address decode
  logic [29:0] ar_off, aw_off;
  logic        ar_err, aw_err;

  always_comb begin
    ar_off = word_offset(axi.araddr, BASE_ADDR);
    aw_off = word_offset(axi.awaddr, BASE_ADDR);
    ar_err = (axi.araddr < BASE_ADDR) || ({2'b00, ar_off} >= DEPTH_WORDS);
    aw_err = (axi.awaddr < BASE_ADDR) || ({2'b00, aw_off} >= DEPTH_WORDS);
  end

  logic unused_prot;
  assign unused_prot = ^{axi.arprot, axi.awprot};

  // Memory
  logic            mem_rd_en;
  logic [31:0]     mem_rd_data;
  logic [3:0]      mem_wr_be;
  logic [IdxW-1:0] r_idx_q, r_idx_d, w_idx_q, w_idx_d;

  // Write payload registers
  logic        w_err_q, w_err_d;
  logic [31:0] w_data_q, w_data_d;
  logic [3:0]  w_strb_q, w_strb_d;

  axi_lite_mem_slave_sdp_bram_we4 #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_mem (
    .clk       (clk),
    .rd_en_i   (mem_rd_en),
    .rd_addr_i (r_idx_q),
    .rd_data_o (mem_rd_data),
    .wr_be_i   (mem_wr_be),
    .wr_addr_i (w_idx_q),
    .wr_data_i (w_data_q)
  );

  // Read FSM
  rstate_t r_state_q, r_state_d;
  logic    r_err_q, r_err_d;
  logic    ar_ready, r_valid;

  always_comb begin
    r_state_d = r_state_q;
    r_idx_d   = r_idx_q;
    r_err_d   = r_err_q;
    mem_rd_en = 1'b0;
    ar_ready  = 1'b0;
    r_valid   = 1'b0;
    unique case (r_state_q)
      R_IDLE: begin
        ar_ready = rstn;
        if (ar_ready && axi.arvalid) begin
          r_idx_d   = ar_off[IdxW-1:0];
          r_err_d   = ar_err;
          r_state_d = R_READ;
        end
      end
      R_READ: begin
        mem_rd_en = 1'b1;
        r_state_d = R_RESP;
      end
      R_RESP: begin
        r_valid = rstn;
        if (r_valid && axi.rready) begin
          r_state_d = R_IDLE;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state_q <= R_IDLE;
    end else begin
      r_state_q <= r_state_d;
    end
  end

  always_ff @(posedge clk) begin
    r_idx_q <= r_idx_d;
    r_err_q <= r_err_d;
  end

  assign axi.arready = ar_ready;
  assign axi.rvalid  = r_valid;
  assign axi.rresp   = (r_valid && r_err_q) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
  assign axi.rdata   = (r_valid && !r_err_q) ? mem_rd_data : 32'h0;

  // Write FSM: AW and W are captured independently in W_IDLE.
  wstate_t w_state_q, w_state_d;
  logic    aw_got_q, aw_got_d, w_got_q, w_got_d;
  logic    aw_ready, w_ready, b_valid;

  always_comb begin
    w_state_d = w_state_q;
    aw_got_d  = aw_got_q;
    w_got_d   = w_got_q;
    w_idx_d   = w_idx_q;
    w_err_d   = w_err_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    mem_wr_be = 4'b0000;
    aw_ready  = 1'b0;
    w_ready   = 1'b0;
    b_valid   = 1'b0;
    unique case (w_state_q)
      W_IDLE: begin
        aw_ready = rstn && !aw_got_q;
        w_ready  = rstn && !w_got_q;
        if (aw_ready && axi.awvalid) begin
          w_idx_d  = aw_off[IdxW-1:0];
          w_err_d  = aw_err;
          aw_got_d = 1'b1;
        end
        if (w_ready && axi.wvalid) begin
          w_data_d = axi.wdata;
          w_strb_d = axi.wstrb;
          w_got_d  = 1'b1;
        end
        if (aw_got_q && w_got_q) begin
          w_state_d = W_WRITE;
        end
      end
      W_WRITE: begin
        mem_wr_be = w_err_q ? 4'b0000 : w_strb_q;
        aw_got_d  = 1'b0;
        w_got_d   = 1'b0;
        w_state_d = W_RESP;
      end
      W_RESP: begin
        b_valid = rstn;
        if (b_valid && axi.bready) begin
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      w_state_q <= W_IDLE;
      aw_got_q  <= 1'b0;
      w_got_q   <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      aw_got_q  <= aw_got_d;
      w_got_q   <= w_got_d;
    end
  end

  always_ff @(posedge clk) begin
    w_idx_q  <= w_idx_d;
    w_err_q  <= w_err_d;
    w_data_q <= w_data_d;
    w_strb_q <= w_strb_d;
  end

  assign axi.awready = aw_ready;
  assign axi.wready  = w_ready;
  assign axi.bvalid  = b_valid;
  assign axi.bresp   = (b_valid && w_err_q) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;

endmodule
